// File: rtl/aes_v2_issue.sv
// Issue queue in front of a scalar AES instruction unit: request FIFO, one
// in-flight op, and a 2-entry in-order result buffer.
//
//   state  | meaning
//   IDLE   | nothing presented to the unit
//   EXEC   | FIFO head presented to the unit, waiting for aes_ready
//   WAIT   | work queued but result buffer full
module aes_v2_issue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             g_clk,
  input  logic             g_reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_sub,
  input  logic             req_enc,
  input  logic [31:0]      req_rs1,
  input  logic [31:0]      req_rs2,
  input  logic [TAG_W-1:0] req_tag,
  output logic             aes_valid,
  output logic             aes_sub,
  output logic             aes_enc,
  output logic [31:0]      aes_rs1,
  output logic [31:0]      aes_rs2,
  input  logic             aes_ready,
  input  logic [31:0]      aes_rd,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_rd,
  output logic [TAG_W-1:0] rsp_tag,
  input  logic             flush,
  output logic             busy
);
  localparam int PW = $clog2(DEPTH);
  localparam int EW = 66 + TAG_W;
  localparam logic [PW:0] L_FULL = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WAIT} state_t;
  state_t r_state, w_state_nxt;

  logic [EW-1:0]    r_fifo [DEPTH];
  logic [PW-1:0]    r_wptr, r_rptr;
  logic [PW:0]      r_count;
  logic [31:0]      r_ob_rd [2];
  logic [TAG_W-1:0] r_ob_tag [2];
  logic             r_ob_wptr, r_ob_rptr;
  logic [1:0]       r_oc;

  logic             w_push, w_cap, w_rsp_pop;
  logic [EW-1:0]    w_head;
  logic [TAG_W-1:0] w_head_tag;
  logic [PW:0]      w_count_nxt;
  logic [1:0]       w_oc_nxt;

  assign w_head = r_fifo[r_rptr];
  assign {aes_sub, aes_enc, aes_rs1, aes_rs2} = w_head[EW-1:TAG_W];
  assign w_head_tag = w_head[TAG_W-1:0];

  assign req_ready = !g_reset && (r_count != L_FULL) && !flush;
  assign aes_valid = (r_state == S_EXEC);
  assign rsp_valid = (r_oc != 2'd0);
  assign rsp_rd    = r_ob_rd[r_ob_rptr];
  assign rsp_tag   = r_ob_tag[r_ob_rptr];
  assign busy      = (r_state != S_IDLE) || (r_count != '0) || (r_oc != 2'd0);

  // flush drops the in-flight op even when the unit completes this cycle
  assign w_push      = req_valid && req_ready;
  assign w_cap       = aes_valid && aes_ready && !flush;
  assign w_rsp_pop   = rsp_valid && rsp_ready;
  assign w_count_nxt = r_count + (PW+1)'(w_push) - (PW+1)'(w_cap);
  assign w_oc_nxt    = r_oc + 2'(w_cap) - 2'(w_rsp_pop);

  always_ff @(posedge g_clk) begin
    if (w_push) r_fifo[r_wptr] <= {req_sub, req_enc, req_rs1, req_rs2, req_tag};
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_cap)  r_rptr <= r_rptr + PW'(1);
      r_count <= w_count_nxt;
    end
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      r_ob_rd[0]  <= '0;
      r_ob_rd[1]  <= '0;
      r_ob_tag[0] <= '0;
      r_ob_tag[1] <= '0;
      r_ob_wptr   <= 1'b0;
      r_ob_rptr   <= 1'b0;
      r_oc        <= 2'd0;
    end else begin
      if (w_cap) begin
        r_ob_rd[r_ob_wptr]  <= aes_rd;
        r_ob_tag[r_ob_wptr] <= w_head_tag;
        r_ob_wptr           <= ~r_ob_wptr;
      end
      if (w_rsp_pop) r_ob_rptr <= ~r_ob_rptr;
      r_oc <= w_oc_nxt;
    end
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) w_state_nxt = (r_oc != 2'd2) ? S_EXEC : S_WAIT;
      end
      S_EXEC: begin
        if (aes_ready) begin
          if (w_count_nxt != '0) w_state_nxt = (w_oc_nxt != 2'd2) ? S_EXEC : S_WAIT;
          else                   w_state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (r_count == '0)       w_state_nxt = S_IDLE;
        else if (r_oc != 2'd2)   w_state_nxt = S_EXEC;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (flush) w_state_nxt = S_IDLE;
  end

endmodule

// File: tb/tb_aes_v2_issue.sv
// Bench for aes_v2_issue: emulates the AES unit, keeps a queue-level model of
// accepted / completed / returned ops and compares every cycle.
module tb_aes_v2_issue;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic        g_clk, g_reset;
  logic        req_valid, req_ready, req_sub, req_enc;
  logic [31:0] req_rs1, req_rs2;
  logic [3:0]  req_tag;
  logic        aes_valid, aes_sub, aes_enc, aes_ready;
  logic [31:0] aes_rs1, aes_rs2, aes_rd;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rd;
  logic [3:0]  rsp_tag;
  logic        flush, busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {logic sub; logic enc; logic [31:0] rs1; logic [31:0] rs2; logic [3:0] tag;} req_t;
  typedef struct {logic [31:0] rd; logic [3:0] tag;} rsp_t;
  req_t       pend_q[$];
  rsp_t       out_q[$];
  logic [3:0] rx_tags[$];
  int         pop_cyc[$];

  aes_v2_issue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .g_clk(g_clk), .g_reset(g_reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_sub(req_sub), .req_enc(req_enc),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_tag(req_tag),
    .aes_valid(aes_valid), .aes_sub(aes_sub), .aes_enc(aes_enc),
    .aes_rs1(aes_rs1), .aes_rs2(aes_rs2), .aes_ready(aes_ready), .aes_rd(aes_rd),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rd(rsp_rd), .rsp_tag(rsp_tag),
    .flush(flush), .busy(busy)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  function automatic void chk(string name, logic [95:0] act, logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // GF(2^8) helpers for the AES unit emulation
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] sb(input logic [7:0] x);
    logic [7:0] inv = 8'h01;
    if (x == 8'h00) inv = 8'h00;
    else for (int i = 0; i < 254; i++) inv = gm(inv, x);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] isb(input logic [7:0] y);
    for (int v = 0; v < 256; v++) if (sb(8'(v)) == y) return 8'(v);
    return 8'h00;
  endfunction

  // Column formed from rs1 low half and rs2 high half, byte 0 in bits 7:0
  function automatic logic [31:0] aes_fn(input logic sub, input logic enc,
                                         input logic [31:0] rs1, input logic [31:0] rs2);
    logic [31:0] w;
    logic [7:0]  a[4];
    logic [7:0]  b[4];
    w = {rs2[31:16], rs1[15:0]};
    for (int i = 0; i < 4; i++) a[i] = w[8*i +: 8];
    if (sub) begin
      for (int i = 0; i < 4; i++) b[i] = enc ? sb(a[i]) : isb(a[i]);
    end else if (enc) begin
      b[0] = gm(a[0], 8'd2) ^ gm(a[1], 8'd3) ^ a[2] ^ a[3];
      b[1] = a[0] ^ gm(a[1], 8'd2) ^ gm(a[2], 8'd3) ^ a[3];
      b[2] = a[0] ^ a[1] ^ gm(a[2], 8'd2) ^ gm(a[3], 8'd3);
      b[3] = gm(a[0], 8'd3) ^ a[1] ^ a[2] ^ gm(a[3], 8'd2);
    end else begin
      b[0] = gm(a[0], 8'd14) ^ gm(a[1], 8'd11) ^ gm(a[2], 8'd13) ^ gm(a[3], 8'd9);
      b[1] = gm(a[0], 8'd9)  ^ gm(a[1], 8'd14) ^ gm(a[2], 8'd11) ^ gm(a[3], 8'd13);
      b[2] = gm(a[0], 8'd13) ^ gm(a[1], 8'd9)  ^ gm(a[2], 8'd14) ^ gm(a[3], 8'd11);
      b[3] = gm(a[0], 8'd11) ^ gm(a[1], 8'd13) ^ gm(a[2], 8'd9)  ^ gm(a[3], 8'd14);
    end
    return {b[3], b[2], b[1], b[0]};
  endfunction

  assign aes_rd = aes_fn(aes_sub, aes_enc, aes_rs1, aes_rs2);

  // Per-cycle compare against the queue model, then apply this cycle's handshakes
  always @(negedge g_clk) begin
    cyc++;
    if (g_reset) begin
      chk("rst_aes_valid", aes_valid, 1'b0);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_req_ready", req_ready, 1'b0);
      chk("rst_rsp_data", {rsp_rd, rsp_tag}, 36'h0);
      pend_q.delete();
      out_q.delete();
    end else begin
      req_t p;
      rsp_t r;
      logic acc, cap, pop;
      chk("req_ready", req_ready, (pend_q.size() < DEPTH) && !flush);
      chk("busy", busy, (pend_q.size() != 0) || (out_q.size() != 0));
      chk("rsp_valid", rsp_valid, out_q.size() != 0);
      if (out_q.size() != 0) chk("rsp_data", {rsp_rd, rsp_tag}, {out_q[0].rd, out_q[0].tag});
      if (pend_q.size() == 0) chk("aes_valid_empty", aes_valid, 1'b0);
      else if (aes_valid)
        chk("aes_ops", {aes_sub, aes_enc, aes_rs1, aes_rs2},
            {pend_q[0].sub, pend_q[0].enc, pend_q[0].rs1, pend_q[0].rs2});
      if (out_q.size() == 2) chk("aes_valid_ob_full", aes_valid, 1'b0);

      acc = req_valid && req_ready;
      cap = aes_valid && aes_ready && !flush;
      pop = rsp_valid && rsp_ready;
      if (pop) begin
        rx_tags.push_back(rsp_tag);
        pop_cyc.push_back(cyc);
        if (out_q.size() != 0) void'(out_q.pop_front());
      end
      if (cap && pend_q.size() != 0) begin
        r.rd  = aes_fn(pend_q[0].sub, pend_q[0].enc, pend_q[0].rs1, pend_q[0].rs2);
        r.tag = pend_q[0].tag;
        out_q.push_back(r);
        void'(pend_q.pop_front());
      end
      if (flush) pend_q.delete();
      if (acc) begin
        p.sub = req_sub; p.enc = req_enc; p.rs1 = req_rs1; p.rs2 = req_rs2; p.tag = req_tag;
        pend_q.push_back(p);
      end
    end
  end

  task automatic step();
    @(posedge g_clk);
    #1;
  endtask

  task automatic push(input logic sub, input logic enc, input logic [31:0] rs1,
                      input logic [31:0] rs2, input logic [3:0] tag);
    int n = 0;
    req_sub = sub; req_enc = enc; req_rs1 = rs1; req_rs2 = rs2; req_tag = tag;
    req_valid = 1'b1;
    @(negedge g_clk);
    while (!req_ready && n < 100) begin
      @(negedge g_clk);
      n++;
    end
    if (n >= 100) chk("push_timeout", req_ready, 1'b1);
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int n = 0;
    @(negedge g_clk);
    while (!rsp_valid && n < 100) begin
      @(negedge g_clk);
      n++;
    end
    chk("rsp_arrives", rsp_valid, 1'b1);
  endtask

  task automatic wait_aes();
    int n = 0;
    @(negedge g_clk);
    while (!aes_valid && n < 100) begin
      @(negedge g_clk);
      n++;
    end
    chk("aes_valid_arrives", aes_valid, 1'b1);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge g_clk);
    while (busy && n < 200) begin
      @(negedge g_clk);
      n++;
    end
    chk("idle_reached", busy, 1'b0);
    step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    g_reset = 1'b1; req_valid = 1'b0; req_sub = 1'b0; req_enc = 1'b0;
    req_rs1 = '0; req_rs2 = '0; req_tag = '0;
    aes_ready = 1'b1; rsp_ready = 1'b1; flush = 1'b0;
    repeat (3) @(posedge g_clk);
    #1;
    g_reset = 1'b0;
    @(negedge g_clk);
    chk("req_ready_after_reset", req_ready, 1'b1);
    step();

    // single-cycle unit latency, SubBytes encrypt of zero
    push(1'b1, 1'b1, 32'h0, 32'h0, 4'd3);
    @(negedge g_clk);
    chk("lat_n1_aes_valid", aes_valid, 1'b0);
    @(negedge g_clk);
    chk("lat_n2_aes_valid", aes_valid, 1'b1);
    chk("lat_n2_rsp_valid", rsp_valid, 1'b0);
    @(negedge g_clk);
    chk("lat_n3_rsp_valid", rsp_valid, 1'b1);
    chk("sub_enc_rd", rsp_rd, 32'h63636363);
    chk("sub_enc_tag", rsp_tag, 4'd3);
    step();

    push(1'b0, 1'b1, 32'h000013DB, 32'h45530000, 4'd1);
    wait_rsp();
    chk("mix_enc_rd", rsp_rd, 32'hBCA14D8E);
    step();
    push(1'b0, 1'b0, 32'h00004D8E, 32'hBCA10000, 4'd2);
    wait_rsp();
    chk("mix_dec_rd", rsp_rd, 32'h455313DB);
    step();
    wait_idle();

    // sustained throughput
    pop_cyc.delete();
    for (int i = 0; i < 8; i++)
      push(i[0], 1'b1, 32'(i * 32'h01010101), 32'(i * 32'h00030000), 4'(i + 8));
    wait_idle();
    chk("tput_count", pop_cyc.size(), 8);
    if (pop_cyc.size() == 8) chk("tput_span", pop_cyc[7] - pop_cyc[0], 7);

    // backpressure fills output buffer then FIFO
    rsp_ready = 1'b0;
    rx_tags.delete();
    for (int i = 0; i < 6; i++) push(1'b1, 1'b1, 32'(i), 32'(i << 16), 4'(i));
    step();
    step();
    @(negedge g_clk);
    chk("bp_req_ready", req_ready, 1'b0);
    chk("bp_aes_valid", aes_valid, 1'b0);
    chk("bp_busy", busy, 1'b1);
    chk("bp_rsp_valid", rsp_valid, 1'b1);
    chk("bp_rsp_tag", rsp_tag, 4'd0);
    step();
    rsp_ready = 1'b1;
    wait_idle();
    chk("bp_count", rx_tags.size(), 6);
    for (int i = 0; i < rx_tags.size() && i < 6; i++) chk("bp_order", rx_tags[i], 4'(i));

    // flush while the unit completes tag 0
    aes_ready = 1'b0;
    rx_tags.delete();
    for (int i = 0; i < 3; i++) push(1'b0, 1'b1, 32'(i + 1), 32'h1234_0000, 4'(i));
    wait_aes();
    step();
    flush = 1'b1;
    aes_ready = 1'b1;
    @(negedge g_clk);
    chk("fl_req_ready", req_ready, 1'b0);
    step();
    flush = 1'b0;
    @(negedge g_clk);
    chk("fl_busy", busy, 1'b0);
    chk("fl_aes_valid", aes_valid, 1'b0);
    chk("fl_rsp_valid", rsp_valid, 1'b0);
    repeat (5) step();
    chk("fl_no_rsp", rx_tags.size(), 0);

    // flush leaves buffered results intact
    rsp_ready = 1'b0;
    rx_tags.delete();
    for (int i = 4; i < 7; i++) push(1'b1, 1'b0, 32'(i * 7), 32'(i << 20), 4'(i));
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    rsp_ready = 1'b1;
    wait_idle();
    chk("flob_count", rx_tags.size(), 2);
    if (rx_tags.size() == 2) begin
      chk("flob_tag0", rx_tags[0], 4'd4);
      chk("flob_tag1", rx_tags[1], 4'd5);
    end

    // multi-cycle unit: operands held while aes_ready is low
    aes_ready = 1'b0;
    rx_tags.delete();
    push(1'b0, 1'b1, 32'h000013DB, 32'h45530000, 4'd7);
    wait_aes();
    step();
    for (int i = 0; i < 4; i++) begin
      @(negedge g_clk);
      chk("mc_aes_valid", aes_valid, 1'b1);
      chk("mc_ops", {aes_sub, aes_enc, aes_rs1, aes_rs2},
          {1'b0, 1'b1, 32'h000013DB, 32'h45530000});
      chk("mc_rsp_valid", rsp_valid, 1'b0);
    end
    step();
    aes_ready = 1'b1;
    step();
    aes_ready = 1'b0;
    wait_rsp();
    chk("mc_rd", rsp_rd, 32'hBCA14D8E);
    chk("mc_tag", rsp_tag, 4'd7);
    step();
    wait_idle();
    chk("mc_single", rx_tags.size(), 1);

    // reset while an op is executing
    rx_tags.delete();
    push(1'b1, 1'b1, 32'h5, 32'h5, 4'd9);
    wait_aes();
    step();
    g_reset = 1'b1;
    step();
    step();
    g_reset = 1'b0;
    aes_ready = 1'b1;
    repeat (10) step();
    chk("rst_no_rsp", rx_tags.size(), 0);
    chk("rst_idle", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
